// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// Module : wb_regfile_pkg
// Brief  : Shared widths and constants for the GPR / HI-LO register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

  localparam int   REG_BUS      = 32;
  localparam int   REG_ADDR_BUS = 5;
  localparam int   REG_NUM      = 32;

  localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;
  localparam logic                    WRITE_ENABLE = 1'b1;
  localparam logic                    READ_ENABLE  = 1'b1;
  localparam logic                    RST_ENABLE   = 1'b1;

endpackage : wb_regfile_pkg

`default_nettype wire

// File: rtl/wb_regfile_hilo.sv
// ============================================================================
// Module : hilo_reg
// Brief  : HI/LO pair, loaded together; no bypass on the outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [REG_BUS-1:0] hi_i,
  input  logic [REG_BUS-1:0] lo_i,
  output logic [REG_BUS-1:0] hi_o,
  output logic [REG_BUS-1:0] lo_o
);

  logic [REG_BUS-1:0] r_hi;
  logic [REG_BUS-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_hi <= ZERO_WORD;
      r_lo <= ZERO_WORD;
    end else if (we == WRITE_ENABLE) begin
      r_hi <= hi_i;
      r_lo <= lo_i;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule : hilo_reg

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module : wb_regfile
// Brief  : 32x32 GPR file, two combinational read ports with write-through
//          bypass, plus the HI/LO register pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_ADDR_BUS-1:0] waddr,
  input  logic [REG_BUS-1:0]      wdata,
  input  logic                    re1,
  input  logic [REG_ADDR_BUS-1:0] raddr1,
  output logic [REG_BUS-1:0]      rdata1,
  input  logic                    re2,
  input  logic [REG_ADDR_BUS-1:0] raddr2,
  output logic [REG_BUS-1:0]      rdata2,
  input  logic                    whilo,
  input  logic [REG_BUS-1:0]      hi_i,
  input  logic [REG_BUS-1:0]      lo_i,
  output logic [REG_BUS-1:0]      hi_o,
  output logic [REG_BUS-1:0]      lo_o
);

  logic [REG_BUS-1:0] r_gpr [REG_NUM];
  logic               w_wr_valid;

  // Entry 0 is held at zero so the array can be indexed by any address.
  assign w_wr_valid = (we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_gpr[i] <= ZERO_WORD;
      end
    end else if (w_wr_valid) begin
      r_gpr[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZERO_WORD;
    if (rst == RST_ENABLE || re1 != READ_ENABLE || raddr1 == NOP_REG_ADDR) begin
      rdata1 = ZERO_WORD;
    end else if (we == WRITE_ENABLE && raddr1 == waddr) begin
      rdata1 = wdata;
    end else begin
      rdata1 = r_gpr[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZERO_WORD;
    if (rst == RST_ENABLE || re2 != READ_ENABLE || raddr2 == NOP_REG_ADDR) begin
      rdata2 = ZERO_WORD;
    end else if (we == WRITE_ENABLE && raddr2 == waddr) begin
      rdata2 = wdata;
    end else begin
      rdata2 = r_gpr[raddr2];
    end
  end

  hilo_reg u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (whilo),
    .hi_i (hi_i),
    .lo_i (lo_i),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule : wb_regfile

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module : tb_wb_regfile
// Brief  : Directed self-checking bench for wb_regfile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_vec;
  int n_err;

  wb_regfile u_dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .whilo  (whilo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    whilo = 0; hi_i = 0; lo_i = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    re1 = 1; raddr1 = 5;
    tick();
    n_vec++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      $display("FAIL reset_first_edge hi_o=%h lo_o=%h expected 0/0", hi_o, lo_o);
      n_err++;
    end
    tick();
    tick();
    n_vec++;
    if (rdata1 !== 32'h0) begin
      $display("FAIL reset_during rdata1=%h expected 00000000", rdata1);
      n_err++;
    end
    rst = 0;
    #1;
    n_vec++;
    if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      $display("FAIL reset_after rdata1=%h hi_o=%h lo_o=%h expected all 0", rdata1, hi_o, lo_o);
      n_err++;
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1; waddr = 3; wdata = 32'hDEADBEEF;
    tick();
    idle();
    re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
    #1;
    n_vec++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
      $display("FAIL write_read rdata1=%h rdata2=%h expected deadbeef", rdata1, rdata2);
      n_err++;
    end
    re1 = 0;
    #1;
    n_vec++;
    if (rdata1 !== 32'h0) begin
      $display("FAIL read_disabled rdata1=%h expected 00000000", rdata1);
      n_err++;
    end
  endtask

  task automatic test_bypass();
    idle();
    we = 1; waddr = 7; wdata = 32'h12345678;
    re2 = 1; raddr2 = 7; re1 = 1; raddr1 = 7;
    #1;
    n_vec++;
    if (rdata2 !== 32'h12345678 || rdata1 !== 32'h12345678) begin
      $display("FAIL bypass rdata1=%h rdata2=%h expected 12345678", rdata1, rdata2);
      n_err++;
    end
    tick();
    we = 0; wdata = 32'h0;
    #1;
    n_vec++;
    if (rdata2 !== 32'h12345678) begin
      $display("FAIL bypass_stored rdata2=%h expected 12345678", rdata2);
      n_err++;
    end
  endtask

  task automatic test_r0();
    idle();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF;
    re1 = 1; raddr1 = 0;
    #1;
    n_vec++;
    if (rdata1 !== 32'h0) begin
      $display("FAIL r0_same_cycle rdata1=%h expected 00000000", rdata1);
      n_err++;
    end
    tick();
    we = 0;
    #1;
    n_vec++;
    if (rdata1 !== 32'h0) begin
      $display("FAIL r0_later rdata1=%h expected 00000000", rdata1);
      n_err++;
    end
  endtask

  task automatic test_we_low();
    idle();
    we = 0; waddr = 3; wdata = 32'h11111111;
    re1 = 1; raddr1 = 3;
    #1;
    n_vec++;
    if (rdata1 !== 32'hDEADBEEF) begin
      $display("FAIL we_low_no_bypass rdata1=%h expected deadbeef", rdata1);
      n_err++;
    end
    tick();
    n_vec++;
    if (rdata1 !== 32'hDEADBEEF) begin
      $display("FAIL we_low_no_write rdata1=%h expected deadbeef", rdata1);
      n_err++;
    end
  endtask

  task automatic test_hilo();
    idle();
    whilo = 1; hi_i = 32'hA5A5A5A5; lo_i = 32'h5A5A5A5A;
    #1;
    n_vec++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      $display("FAIL hilo_same_cycle hi_o=%h lo_o=%h expected 0/0", hi_o, lo_o);
      n_err++;
    end
    tick();
    whilo = 0; hi_i = 32'h1; lo_i = 32'h2;
    #1;
    n_vec++;
    if (hi_o !== 32'hA5A5A5A5 || lo_o !== 32'h5A5A5A5A) begin
      $display("FAIL hilo_next hi_o=%h lo_o=%h expected a5a5a5a5/5a5a5a5a", hi_o, lo_o);
      n_err++;
    end
    tick();
    n_vec++;
    if (hi_o !== 32'hA5A5A5A5 || lo_o !== 32'h5A5A5A5A) begin
      $display("FAIL hilo_hold hi_o=%h lo_o=%h expected a5a5a5a5/5a5a5a5a", hi_o, lo_o);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012};
    idle();
    for (int i = 0; i < 3; i++) begin
      we = 1; waddr = 5'(10 + i); wdata = vals[i];
      re1 = 1; raddr1 = 5'(10 + i);
      re2 = 1; raddr2 = 5'(9 + i);
      #1;
      n_vec++;
      if (rdata1 !== vals[i]) begin
        $display("FAIL b2b_bypass_%0d rdata1=%h expected %h", i, rdata1, vals[i]);
        n_err++;
      end
      if (i > 0) begin
        n_vec++;
        if (rdata2 !== vals[i-1]) begin
          $display("FAIL b2b_prev_%0d rdata2=%h expected %h", i, rdata2, vals[i-1]);
          n_err++;
        end
      end
      tick();
    end
    idle();
    re1 = 1; raddr1 = 12; re2 = 1; raddr2 = 12;
    #1;
    n_vec++;
    if (rdata1 !== 32'hC0DE0012 || rdata2 !== rdata1) begin
      $display("FAIL dual_same_addr rdata1=%h rdata2=%h expected c0de0012", rdata1, rdata2);
      n_err++;
    end
    raddr2 = 10;
    #1;
    n_vec++;
    if (rdata1 !== 32'hC0DE0012 || rdata2 !== 32'hC0DE0010) begin
      $display("FAIL dual_indep rdata1=%h rdata2=%h expected c0de0012/c0de0010", rdata1, rdata2);
      n_err++;
    end
  endtask

  task automatic test_reset_collision();
    idle();
    we = 1; waddr = 9; wdata = 32'h1;
    tick();
    idle();
    re1 = 1; raddr1 = 9;
    #1;
    n_vec++;
    if (rdata1 !== 32'h1) begin
      $display("FAIL coll_setup rdata1=%h expected 00000001", rdata1);
      n_err++;
    end
    rst = 1;
    we = 1; waddr = 9; wdata = 32'h2;
    whilo = 1; hi_i = 32'h3; lo_i = 32'h4;
    #1;
    n_vec++;
    if (rdata1 !== 32'h0) begin
      $display("FAIL coll_rst_read rdata1=%h expected 00000000", rdata1);
      n_err++;
    end
    tick();
    rst = 0;
    idle();
    re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 3;
    #1;
    n_vec++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      $display("FAIL coll_after rdata1=%h rdata2=%h hi_o=%h lo_o=%h expected all 0",
               rdata1, rdata2, hi_o, lo_o);
      n_err++;
    end
    we = 1; waddr = 9; wdata = 32'h5;
    tick();
    we = 0;
    #1;
    n_vec++;
    if (rdata1 !== 32'h5) begin
      $display("FAIL coll_resume rdata1=%h expected 00000005", rdata1);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_we_low();
    test_hilo();
    test_back_to_back();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wb_regfile

`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high (RstEnable = 1).
REQ-003 SHALL have port we  input  1  GPR write enable, driven by writeback stage wb_wreg.
REQ-004 SHALL have port waddr  input  5  GPR write address (wb_wd).
REQ-005 SHALL have port wdata  input  32  GPR write data (wb_wdata).
REQ-006 SHALL have ports re1, re2  input  1 each  read-port enables from decode.
REQ-007 SHALL have ports raddr1, raddr2  input  5 each  read addresses.
REQ-008 SHALL have ports rdata1, rdata2  output  32 each  read data, combinational.
REQ-009 SHALL have port whilo  input  1  HI/LO write enable (wb_whilo).
REQ-010 SHALL have ports hi_i, lo_i  input  32 each  HI/LO write data (wb_hi, wb_lo).
REQ-011 SHALL have ports hi_o, lo_o  output  32 each  registered HI/LO contents.

Function
REQ-012 SHALL hold 32 GPRs of 32 bits; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-013 SHALL write wdata into GPR[waddr] on the rising edge where rst=0, we=1, waddr!=0; latency 1 cycle.
REQ-014 Read port n SHALL return 0 when rst=1, or ren=0, or raddrn=0.
REQ-015 Otherwise, if we=1 and raddrn==waddr, read port n SHALL return wdata in the same cycle (write-through bypass).
REQ-016 Otherwise, read port n SHALL return GPR[raddrn].
REQ-017 Both read ports SHALL operate independently; equal addresses on both ports SHALL return identical data.
REQ-018 SHALL load hi_i and lo_i into HI and LO on the rising edge where rst=0, whilo=1; both update together, never only one.
REQ-019 hi_o/lo_o SHALL reflect HI/LO registers only (no bypass); new values are visible the cycle after the write.
REQ-020 When rst=1 and any write enable are asserted simultaneously, reset SHALL win and the write SHALL be lost.
REQ-021 When we=0, waddr/wdata SHALL have no effect on storage or bypass.

Reset
REQ-022 On a rising edge with rst=1, all GPRs 1..31, HI and LO SHALL clear to 0.
REQ-023 While rst=1, rdata1, rdata2 SHALL be 0; hi_o, lo_o SHALL be 0 from the first reset edge.
REQ-024 Reset asserted mid-stream SHALL discard any in-flight write at that edge; normal operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-025 Widths and constants (RegBus=32, RegAddrBus=5, RegNum=32, ZeroWord, NOPRegAddr, WriteEnable, ReadEnable, RstEnable) SHALL come from the shared defines package; no local literals.
REQ-026 HI/LO storage SHALL be a separate sub-module hilo_reg (clk, rst, we, hi_i, lo_i, hi_o, lo_o), instantiated once.
REQ-027 GPR storage SHALL be flops; no vendor RAM macros, because reset must clear all entries.

Verification
REQ-028 Reset: 3 cycles of rst=1, then re1=1 raddr1=5 -> rdata1=0; hi_o=lo_o=0.
REQ-029 Write/read: we=1 waddr=3 wdata=0xDEADBEEF, next cycle re1=1 raddr1=3 -> rdata1=0xDEADBEEF; re1=0 -> 0.
REQ-030 Bypass: in one cycle we=1 waddr=7 wdata=0x12345678, re2=1 raddr2=7 -> rdata2=0x12345678 in that cycle.
REQ-031 R0: we=1 waddr=0 wdata=0xFFFFFFFF; then raddr1=0 re1=1 -> 0, same cycle and later.
REQ-032 HI/LO: whilo=1 hi_i=0xA5A5A5A5 lo_i=0x5A5A5A5A -> hi_o/lo_o unchanged in that cycle, equal the new values next cycle.
REQ-033 Reset collision: GPR[9]=0x1; edge with rst=1, we=1 waddr=9 wdata=0x2, whilo=1 -> GPR[9]=0, HI=LO=0 afterwards.
